// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the RISC core and its instruction
//               memory controller: FSM encoding, NOP opcode, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam int c_risc_a_size = 10;
    localparam int c_risc_i_size = 16;

    // Matches the core's 16-bit NOP encoding
    localparam logic [15:0] c_nop_opcode = 16'h0000;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/instr_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl_if
// Description : Program-load stream and instruction-fetch bus of the
//               instruction memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_ctrl_if
    import risc_pkg::*;
#(
    parameter int A_SIZE = c_risc_a_size,
    parameter int I_SIZE = c_risc_i_size
);

    logic              prog_valid;
    logic              prog_ready;
    logic [I_SIZE-1:0] prog_data;
    logic              prog_last;
    logic              reload;
    logic              core_rst;
    logic [A_SIZE-1:0] pc;
    logic [I_SIZE-1:0] instruction;
    logic              instr_valid;
    logic [A_SIZE:0]   prog_count;
    logic              err_overflow;

    // Program source and core side
    modport master (
        output prog_valid, prog_data, prog_last, reload, pc,
        input  prog_ready, core_rst, instruction, instr_valid, prog_count, err_overflow
    );

    // Controller side
    modport slave (
        input  prog_valid, prog_data, prog_last, reload, pc,
        output prog_ready, core_rst, instruction, instr_valid, prog_count, err_overflow
    );

endinterface : instr_mem_ctrl_if
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_ram
// Description : DEPTH x DW synchronous RAM, one write port, one registered
//               read port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ram #(
    parameter int AW    = 10,
    parameter int DW    = 16,
    parameter int DEPTH = 1024
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : instr_ram
`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_ctrl
// Description : Loads a program over a valid/ready stream, holds the core in
//               reset while loading, then serves fetches with 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl
    import risc_pkg::*;
#(
    parameter int                A_SIZE   = c_risc_a_size,
    parameter int                I_SIZE   = c_risc_i_size,
    parameter int                DEPTH    = 1024,
    parameter logic [I_SIZE-1:0] NOP_WORD = I_SIZE'(c_nop_opcode)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instr_mem_ctrl_if.slave     bus
);

    localparam int c_ram_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ctrl_state_t       r_state;
    logic [A_SIZE:0]   r_wptr;
    logic              r_prog_ready;
    logic              r_core_rst;
    logic              r_err_overflow;
    logic              r_hit;
    logic [I_SIZE-1:0] w_rdata;
    logic              w_xfer;
    logic              w_last_slot;
    logic              w_in_range;

    assign w_xfer      = (r_state == ST_LOAD) && r_prog_ready && bus.prog_valid;
    assign w_last_slot = (r_wptr == (A_SIZE+1)'(DEPTH - 1));
    // Unsigned on A_SIZE+1 bits so a full 2^A_SIZE program still compares correctly
    assign w_in_range  = ({1'b0, bus.pc} < r_wptr);

    instr_ram #(
        .AW    (c_ram_aw),
        .DW    (I_SIZE),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_xfer),
        .i_waddr (r_wptr[c_ram_aw-1:0]),
        .i_wdata (bus.prog_data),
        .i_raddr (bus.pc[c_ram_aw-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_LOAD;
            r_wptr         <= '0;
            r_prog_ready   <= 1'b0;
            r_core_rst     <= 1'b0;
            r_err_overflow <= 1'b0;
            r_hit          <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_prog_ready <= 1'b1;
                    r_hit        <= 1'b0;
                    if (w_xfer) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (bus.prog_last || w_last_slot) begin
                            r_state      <= ST_RUN;
                            r_prog_ready <= 1'b0;
                            r_core_rst   <= 1'b1;
                            if (!bus.prog_last) begin
                                r_err_overflow <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.reload) begin
                        r_state        <= ST_LOAD;
                        r_wptr         <= '0;
                        r_prog_ready   <= 1'b1;
                        r_core_rst     <= 1'b0;
                        r_err_overflow <= 1'b0;
                        r_hit          <= 1'b0;
                    end else begin
                        r_hit <= w_in_range;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // r_hit gates the registered RAM word so stale contents are never exposed
    assign bus.instruction  = r_hit ? w_rdata : NOP_WORD;
    assign bus.instr_valid  = r_hit;
    assign bus.prog_ready   = r_prog_ready;
    assign bus.core_rst     = r_core_rst;
    assign bus.prog_count   = r_wptr;
    assign bus.err_overflow = r_err_overflow;

endmodule : instr_mem_ctrl
`default_nettype wire
